// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM round-robin arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

  // One RAM access as selected from the winning requester.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  // Converts a requester id into its one-hot strobe position.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ram_8x8.sv
// Single-port synchronous RAM with a registered read port. A write in the
// same cycle returns the old contents (read-before-write). Reset clears the
// array and the output register.
module ram_8x8 #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array and read register; the read samples before the write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      data_out <= '0;
    end else begin
      data_out <= mem[addr];
      if (write_en) begin
        mem[addr] <= data_in;
      end
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator: a lone requester always wins, and
// on contention the requester that did not win last time is chosen.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            last_gnt,
  output logic [NUM_REQ-1:0] gnt
);

  // Pure combinational grant selection from the request vector and history.
  always_comb begin
    gnt = '0;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port RAM between two valid/ready requesters using
// round-robin arbitration. The RAM is driven combinationally by the winner,
// and the read data is steered back to that requester one cycle later.
// Each requester also has a saturating grant counter for observation.
module ram_rr_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                ram_write_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data_in,
  input  logic [DATA_W-1:0]   ram_data_out,
  output logic [2*CNT_W-1:0]  grant_cnt
);

  import ram_arb_pkg::*;

  req_id_t          last_gnt;
  req_id_t          pend_id;
  req_id_t          win_id;
  logic             pend_vld;
  logic [1:0]       gnt;
  logic             xfer;
  ram_req_t         win;
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  rr_arb2 u_rr_arb2 (
    .valid    (req_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Grants are held off while reset is high; the grant is already valid-masked.
  always_comb begin
    req_ready = reset ? 2'b00 : gnt;
    xfer      = |req_ready;
    win_id    = req_ready[1];
  end

  // Select the winning request's fields; an idle cycle drives all zeros.
  always_comb begin
    win = '0;
    if (xfer) begin
      win.we    = req_we[win_id];
      win.addr  = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
      win.wdata = req_wdata[int'(win_id)*DATA_W +: DATA_W];
    end
  end

  // The RAM port follows the winner within the same cycle.
  always_comb begin
    ram_write_en = win.we;
    ram_addr     = win.addr;
    ram_data_in  = win.wdata;
  end

  // Round-robin history and the single outstanding-response slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
      pend_vld <= 1'b0;
      pend_id  <= 1'b0;
    end else begin
      pend_vld <= xfer;
      if (xfer) begin
        pend_id  <= win_id;
        last_gnt <= win_id;
      end
    end
  end

  // Per-requester grant counters that stop at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Response strobe and data for the transfer made on the previous edge.
  always_comb begin
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    if (pend_vld && !reset) begin
      rsp_valid = id_to_onehot(pend_id);
      rsp_rdata = ram_data_out;
    end
  end

  // Flatten the counters onto the packed observation port.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter paired with ram_8x8. The reference
// model tracks memory contents, the last winner, the outstanding response and
// the grant counts as plain variables, and each scenario task compares the
// DUT against it.
module tb_ram_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        ram_write_en;
  logic [2:0]  ram_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic [15:0] grant_cnt;

  int n_checks;
  int n_pass;

  // Reference model state
  logic [7:0] m_mem [8];
  int         m_last;
  bit         m_pend;
  int         m_pend_id;
  logic [7:0] m_pend_data;
  int         m_cnt [2];

  // Expected values for the current cycle
  int         e_win;
  logic [1:0] e_ready;
  logic [1:0] e_rsp;
  logic [7:0] e_rdata;
  logic       e_we;
  logic [2:0] e_addr;
  logic [7:0] e_wdata;

  ram_rr_arbiter #(.ADDR_W(3), .DATA_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .grant_cnt    (grant_cnt)
  );

  ram_8x8 #(.ADDR_W(3), .DATA_W(8)) u_ram (
    .clk      (clk),
    .reset    (reset),
    .write_en (ram_write_en),
    .addr     (ram_addr),
    .data_in  (ram_data_in),
    .data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_last      = 1;
    m_pend      = 0;
    m_pend_id   = 0;
    m_pend_data = 8'h00;
    m_cnt[0]    = 0;
    m_cnt[1]    = 0;
  endtask

  // Drive one cycle's requests and work out what the arbiter should do.
  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    if (v == 2'b11)  e_win = (m_last == 0) ? 1 : 0;
    else if (v[0])   e_win = 0;
    else if (v[1])   e_win = 1;
    else             e_win = -1;
    e_ready = 2'b00;
    e_we    = 1'b0;
    e_addr  = 3'd0;
    e_wdata = 8'h00;
    if (e_win == 0) begin
      e_ready = 2'b01; e_we = we[0]; e_addr = a0; e_wdata = d0;
    end else if (e_win == 1) begin
      e_ready = 2'b10; e_we = we[1]; e_addr = a1; e_wdata = d1;
    end
    e_rsp   = m_pend ? ((m_pend_id == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_rdata = m_pend_data;
  endtask

  // Clock edge: a granted access returns the contents at transfer time.
  task automatic advance();
    @(posedge clk);
    if (e_win >= 0) begin
      m_pend      = 1;
      m_pend_id   = e_win;
      m_pend_data = m_mem[e_addr];
      if (e_we) m_mem[e_addr] = e_wdata;
      if (m_cnt[e_win] < 255) m_cnt[e_win]++;
      m_last = e_win;
    end else begin
      m_pend = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11; req_we = 2'b11; req_addr = 6'o55; req_wdata = 16'hBEEF;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) $display("[TB] FAIL reset_ready: got %b want 00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", rsp_rdata); else n_pass++;
    n_checks++; if (grant_cnt !== 16'h0000) $display("[TB] FAIL reset_cnt: got %h want 0000", grant_cnt); else n_pass++;
    n_checks++; if (ram_write_en !== 1'b0) $display("[TB] FAIL reset_ram_we: got %b want 0", ram_write_en); else n_pass++;
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_req(2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00);
    @(negedge clk);
    n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL basic_w_ready: got %b want %b", req_ready, e_ready); else n_pass++;
    n_checks++; if ({ram_write_en, ram_addr, ram_data_in} !== {1'b1, 3'd3, 8'hA5}) $display("[TB] FAIL basic_ram_port: got %b/%0d/%h want 1/3/a5", ram_write_en, ram_addr, ram_data_in); else n_pass++;
    advance();
    set_req(2'b10, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (rsp_valid !== e_rsp) $display("[TB] FAIL basic_wrsp_valid: got %b want %b", rsp_valid, e_rsp); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'h00) $display("[TB] FAIL basic_wrsp_data: got %h want 00", rsp_rdata); else n_pass++;
    n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL basic_r_ready: got %b want %b", req_ready, e_ready); else n_pass++;
    advance();
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b10) $display("[TB] FAIL basic_rrsp_valid: got %b want 10", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'hA5) $display("[TB] FAIL basic_rrsp_data: got %h want a5", rsp_rdata); else n_pass++;
    n_checks++; if (ram_addr !== 3'd0) $display("[TB] FAIL basic_idle_addr: got %0d want 0", ram_addr); else n_pass++;
    advance();
  endtask

  task automatic test_contention();
    set_req(2'b11, 2'b11, 3'd1, 3'd2, 8'h11, 8'h22);
    @(negedge clk);
    n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL cont_pre0_ready: got %b want %b", req_ready, e_ready); else n_pass++;
    advance();
    set_req(2'b10, 2'b10, 3'd1, 3'd2, 8'h11, 8'h22);
    @(negedge clk);
    n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL cont_pre1_ready: got %b want %b", req_ready, e_ready); else n_pass++;
    advance();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_req(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
      else       set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      if (k < 4) begin
        n_checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("[TB] FAIL cont_ready[%0d]: got %b want %b", k, req_ready, e_ready); else n_pass++;
      end
      if (k > 0) begin
        n_checks++; if (rsp_rdata !== ((k % 2 == 1) ? 8'h11 : 8'h22)) $display("[TB] FAIL cont_rdata[%0d]: got %h want %h", k, rsp_rdata, e_rdata); else n_pass++;
      end
      n_checks++; if (rsp_valid !== e_rsp) $display("[TB] FAIL cont_rsp[%0d]: got %b want %b", k, rsp_valid, e_rsp); else n_pass++;
      advance();
    end
  endtask

  task automatic test_req1_only();
    int start;
    start = m_cnt[1];
    for (int k = 0; k < 3; k++) begin
      set_req(2'b10, 2'b00, 3'd0, 3'(k), 8'h00, 8'h00);
      @(negedge clk);
      n_checks++; if (req_ready !== 2'b10) $display("[TB] FAIL r1only_ready[%0d]: got %b want 10", k, req_ready); else n_pass++;
      advance();
    end
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (grant_cnt[15:8] !== 8'(start + 3)) $display("[TB] FAIL r1only_cnt: got %0d want %0d", grant_cnt[15:8], start + 3); else n_pass++;
    advance();
  endtask

  task automatic test_hazards();
    set_req(2'b01, 2'b01, 3'd7, 3'd0, 8'h5A, 8'h00);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) $display("[TB] FAIL haz_w_ready: got %b want 01", req_ready); else n_pass++;
    advance();
    set_req(2'b10, 2'b00, 3'd0, 3'd7, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL haz_r_ready: got %b want %b", req_ready, e_ready); else n_pass++;
    advance();
    set_req(2'b01, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 8'h5A}) $display("[TB] FAIL haz_raw: got %b/%h want 10/5a", rsp_valid, rsp_rdata); else n_pass++;
    advance();
    set_req(2'b10, 2'b10, 3'd0, 3'd7, 8'h00, 8'hFF);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 8'h5A}) $display("[TB] FAIL haz_war_read: got %b/%h want 01/5a", rsp_valid, rsp_rdata); else n_pass++;
    advance();
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 8'h5A}) $display("[TB] FAIL haz_war_wack: got %b/%h want 10/5a", rsp_valid, rsp_rdata); else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    set_req(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
    advance();
    reset = 1'b1;
    req_valid = 2'b00;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 2'b00) $display("[TB] FAIL rmid_rsp_in_reset[%0d]: got %b want 00", k, rsp_valid); else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b00) $display("[TB] FAIL rmid_rsp_after: got %b want 00", rsp_valid); else n_pass++;
    n_checks++; if (grant_cnt !== 16'h0000) $display("[TB] FAIL rmid_cnt: got %h want 0000", grant_cnt); else n_pass++;
    advance();
    set_req(2'b11, 2'b00, 3'd3, 3'd7, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) $display("[TB] FAIL rmid_first_win: got %b want 01", req_ready); else n_pass++;
    advance();
    set_req(2'b10, 2'b00, 3'd3, 3'd7, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 8'h00}) $display("[TB] FAIL rmid_cleared3: got %b/%h want 01/00", rsp_valid, rsp_rdata); else n_pass++;
    advance();
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 8'h00}) $display("[TB] FAIL rmid_cleared7: got %b/%h want 10/00", rsp_valid, rsp_rdata); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    logic       hv [2];
    logic       hwe [2];
    logic [2:0] ha [2];
    logic [7:0] hd [2];
    for (int i = 0; i < 2; i++) hv[i] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hv[i]) begin
          hv[i]  = 1'($urandom_range(0, 1));
          hwe[i] = 1'($urandom_range(0, 1));
          ha[i]  = 3'($urandom_range(0, 7));
          hd[i]  = 8'($urandom);
        end
      end
      set_req({hv[1], hv[0]}, {hwe[1], hwe[0]}, ha[0], ha[1], hd[0], hd[1]);
      @(negedge clk);
      n_checks++; if (req_ready !== e_ready) $display("[TB] FAIL rand_ready[%0d]: got %b want %b", k, req_ready, e_ready); else n_pass++;
      n_checks++; if (rsp_valid !== e_rsp) $display("[TB] FAIL rand_rsp[%0d]: got %b want %b", k, rsp_valid, e_rsp); else n_pass++;
      if (e_rsp != 2'b00) begin
        n_checks++; if (rsp_rdata !== e_rdata) $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", k, rsp_rdata, e_rdata); else n_pass++;
      end
      n_checks++; if ({ram_write_en, ram_addr, ram_data_in} !== {e_we, e_addr, e_wdata}) $display("[TB] FAIL rand_ram[%0d]: got %b/%0d/%h want %b/%0d/%h", k, ram_write_en, ram_addr, ram_data_in, e_we, e_addr, e_wdata); else n_pass++;
      n_checks++; if (grant_cnt !== {8'(m_cnt[1]), 8'(m_cnt[0])}) $display("[TB] FAIL rand_cnt[%0d]: got %h want %h", k, grant_cnt, {8'(m_cnt[1]), 8'(m_cnt[0])}); else n_pass++;
      advance();
      for (int i = 0; i < 2; i++) if (e_ready[i]) hv[i] = 1'b0;
    end
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    advance();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      set_req(2'b01, 2'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'd0, 8'($urandom), 8'h00);
      advance();
    end
    set_req(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (grant_cnt[7:0] !== 8'd255) $display("[TB] FAIL sat_cnt0: got %0d want 255", grant_cnt[7:0]); else n_pass++;
    n_checks++; if (grant_cnt[15:8] !== 8'(m_cnt[1])) $display("[TB] FAIL sat_cnt1: got %0d want %0d", grant_cnt[15:8], m_cnt[1]); else n_pass++;
    advance();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_contention();
    test_req1_only();
    test_hazards();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
